// File: rtl/matbi_dma_ctrl_mch_s_axi_if.sv
// AXI4-Lite bundle between the PS AXI-GP master and the multi-channel DMA control register file.
interface matbi_dma_ctrl_mch_s_axi_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/matbi_dma_ctrl_mch_s_axi.sv
// AXI4-Lite control register file for an NUM_CH-channel DMA engine (start/done/idle, pointers, W1C ISR).
// Defining MATBI_DMA_CTRL_PERF_CNT_EN adds per-channel busy-cycle counters at 0xC0 + 4*c.
module matbi_dma_ctrl_mch_s_axi #(
    parameter int NUM_CH             = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    matbi_dma_ctrl_mch_s_axi_if.slave s_axi,
    output logic                      interrupt,
    output logic [NUM_CH-1:0]         ch_ap_start,
    input  logic [NUM_CH-1:0]         ch_ap_done,
    input  logic [NUM_CH-1:0]         ch_ap_ready,
    input  logic [NUM_CH-1:0]         ch_ap_idle,
    output logic [32*NUM_CH-1:0]      ch_rdma_ptr,
    output logic [32*NUM_CH-1:0]      ch_wdma_ptr,
    output logic [32*NUM_CH-1:0]      ch_xfer_byte,
    output logic [1:0]                dbg_wr_state_o,
    output logic [1:0]                dbg_rd_state_o
);
    localparam int          AW          = C_S_AXI_ADDR_WIDTH;
    localparam int          DW          = C_S_AXI_DATA_WIDTH;
    localparam int          SW          = DW / 8;
    localparam logic [31:0] ID_VAL      = 32'h4D43_0000 | 32'(NUM_CH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_RESET, WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_RESET, RD_IDLE, RD_DATA} rd_state_e;

    // Handshakes: a beat transfers on the rising edge where VALID and READY are both high;
    // the master holds VALID and payload stable until then, and READY never depends on VALID.
    function automatic logic addr_mapped(input logic [AW-1:0] a);
        logic [5:0] idx;
        logic       m;
        idx = a[7:2];
        m   = 1'b0;
        if ((a >> 8) == '0) begin
            if (idx < 6'd4) m = 1'b1;
            else if (int'(idx[5:2]) <= NUM_CH) m = 1'b1;
`ifdef MATBI_DMA_CTRL_PERF_CNT_EN
            else if (idx >= 6'd48 && int'(idx) < 48 + NUM_CH) m = 1'b1;
`endif
        end
        return m;
    endfunction

    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs, wr_en, wr_map, wr_sel;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_strb;
    logic [5:0]        wr_idx;

    rd_state_e         rd_state_q, rd_state_d;
    logic [DW-1:0]     rdata_q, rdata_d, rd_mux;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_hs, rd_map;
    logic [5:0]        rd_idx;

    logic                    gie_q, gie_d, irq_q, irq_d;
    logic [NUM_CH-1:0]       ier_q, ier_d, isr_q, isr_d;
    logic [NUM_CH-1:0]       ap_start_q, ap_start_d, auto_q, auto_d;
    logic [NUM_CH-1:0]       done_q, done_d, ready_q, ready_d, idle_q, idle_d;
    logic [NUM_CH-1:0][31:0] rdma_q, rdma_d, wdma_q, wdma_d, xfer_q, xfer_d;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{wr_addr[1:0], s_axi.araddr[1:0]};

    // Latched AW/W take priority; otherwise the beat on the bus this cycle is the one committing.
    assign wr_addr = aw_held_q ? awaddr_q : s_axi.awaddr;
    assign wr_data = w_held_q  ? wdata_q  : s_axi.wdata;
    assign wr_strb = w_held_q  ? wstrb_q  : s_axi.wstrb;
    assign wr_idx  = wr_addr[7:2];
    assign wr_map  = addr_mapped(wr_addr);
    assign wr_sel  = wr_en && wr_map;

    always_comb begin
        wr_state_d    = wr_state_q;
        aw_held_d     = aw_held_q;
        w_held_d      = w_held_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bresp_d       = bresp_q;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        wr_en         = 1'b0;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        case (wr_state_q)
            WR_RESET: wr_state_d = WR_IDLE;
            WR_IDLE: begin
                s_axi.awready = !aw_held_q;
                s_axi.wready  = !w_held_q;
                aw_hs         = s_axi.awvalid && !aw_held_q;
                w_hs          = s_axi.wvalid && !w_held_q;
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    wr_en      = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_map ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: if (s_axi.bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    assign rd_idx = s_axi.araddr[7:2];
    assign rd_map = addr_mapped(s_axi.araddr);

`ifdef MATBI_DMA_CTRL_PERF_CNT_EN
    logic [NUM_CH-1:0][31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_sel && wr_strb[0] && wr_data[0] && wr_idx == 6'(4 + 4*c)) perf_d[c] = '0;
            else if (!ch_ap_idle[c] && perf_q[c] != 32'hFFFF_FFFF) perf_d[c] = perf_q[c] + 32'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) perf_q <= '0;
        else          perf_q <= perf_d;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (rd_map) begin
            case (rd_idx)
                6'd0:    rd_mux = ID_VAL;
                6'd1:    rd_mux = {31'b0, gie_q};
                6'd2:    rd_mux = 32'(ier_q);
                6'd3:    rd_mux = 32'(isr_q);
                default: rd_mux = '0;
            endcase
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_idx[5:2] == 4'(c + 1)) begin
                    case (rd_idx[1:0])
                        2'd0: rd_mux = {24'b0, auto_q[c], 3'b0, ready_q[c], idle_q[c], done_q[c], ap_start_q[c]};
                        2'd1: rd_mux = rdma_q[c];
                        2'd2: rd_mux = wdma_q[c];
                        default: rd_mux = xfer_q[c];
                    endcase
                end
`ifdef MATBI_DMA_CTRL_PERF_CNT_EN
                if (rd_idx == 6'(48 + c)) rd_mux = perf_q[c];
`endif
            end
        end
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rd_hs         = 1'b0;
        s_axi.arready = 1'b0;
        case (rd_state_q)
            RD_RESET: rd_state_d = RD_IDLE;
            RD_IDLE: begin
                s_axi.arready = 1'b1;
                rd_hs         = s_axi.arvalid;
                if (rd_hs) begin
                    rdata_d    = rd_mux;
                    rresp_d    = rd_map ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: if (s_axi.rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Within each register, clears are applied first so a same-cycle set always wins.
    always_comb begin
        gie_d      = gie_q;
        ier_d      = ier_q;
        isr_d      = isr_q;
        ap_start_d = ap_start_q;
        auto_d     = auto_q;
        done_d     = done_q;
        ready_d    = ready_q;
        idle_d     = ch_ap_idle;
        rdma_d     = rdma_q;
        wdma_d     = wdma_q;
        xfer_d     = xfer_q;
        irq_d      = gie_q & (|isr_q);
        if (wr_sel && wr_strb[0]) begin
            if (wr_idx == 6'd1) gie_d = wr_data[0];
            if (wr_idx == 6'd2) ier_d = wr_data[NUM_CH-1:0];
            if (wr_idx == 6'd3) isr_d = isr_q & ~wr_data[NUM_CH-1:0];
        end
        isr_d = isr_d | (ch_ap_done & ier_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ap_ready[c]) ap_start_d[c] = auto_q[c];
            if (wr_sel && wr_strb[0] && wr_idx == 6'(4 + 4*c)) begin
                auto_d[c] = wr_data[7];
                if (wr_data[0]) ap_start_d[c] = 1'b1;
            end
            if (rd_hs && rd_map && rd_idx == 6'(4 + 4*c)) begin
                done_d[c]  = 1'b0;
                ready_d[c] = 1'b0;
            end
            if (ch_ap_done[c]) done_d[c] = 1'b1;
            if (ch_ap_ready[c] && !auto_q[c]) ready_d[c] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (wr_sel && wr_strb[b]) begin
                    if (wr_idx == 6'(5 + 4*c)) rdma_d[c][8*b +: 8] = wr_data[8*b +: 8];
                    if (wr_idx == 6'(6 + 4*c)) wdma_d[c][8*b +: 8] = wr_data[8*b +: 8];
                    if (wr_idx == 6'(7 + 4*c)) xfer_d[c][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WR_RESET;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rd_state_q <= RD_RESET;
            rdata_q    <= '0;
            rresp_q    <= '0;
            gie_q      <= 1'b0;
            irq_q      <= 1'b0;
            ier_q      <= '0;
            isr_q      <= '0;
            ap_start_q <= '0;
            auto_q     <= '0;
            done_q     <= '0;
            ready_q    <= '0;
            idle_q     <= '0;
            rdma_q     <= '0;
            wdma_q     <= '0;
            xfer_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            gie_q      <= gie_d;
            irq_q      <= irq_d;
            ier_q      <= ier_d;
            isr_q      <= isr_d;
            ap_start_q <= ap_start_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            idle_q     <= idle_d;
            rdma_q     <= rdma_d;
            wdma_q     <= wdma_d;
            xfer_q     <= xfer_d;
        end
    end

    assign s_axi.bvalid   = (wr_state_q == WR_RESP);
    assign s_axi.bresp    = bresp_q;
    assign s_axi.rvalid   = (rd_state_q == RD_DATA);
    assign s_axi.rdata    = rdata_q;
    assign s_axi.rresp    = rresp_q;
    assign interrupt      = irq_q;
    assign ch_ap_start    = ap_start_q;
    assign ch_rdma_ptr    = rdma_q;
    assign ch_wdma_ptr    = wdma_q;
    assign ch_xfer_byte   = xfer_q;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;
endmodule

// File: tb/tb_matbi_dma_ctrl_mch_s_axi.sv
// Directed bench for matbi_dma_ctrl_mch_s_axi with NUM_CH=4: reset, ID, byte masking, W-before-AW,
// start/done/interrupt, auto-restart, unmapped accesses and set-vs-clear races.
module tb_matbi_dma_ctrl_mch_s_axi;
    localparam int NUM_CH = 4;

    logic                 ACLK = 1'b0;
    logic                 ARESETN;
    logic                 interrupt;
    logic [NUM_CH-1:0]    ch_ap_start, ch_ap_done, ch_ap_ready, ch_ap_idle;
    logic [32*NUM_CH-1:0] ch_rdma_ptr, ch_wdma_ptr, ch_xfer_byte;
    logic [1:0]           dbg_wr_state, dbg_rd_state;

    always #5 ACLK = ~ACLK;

    matbi_dma_ctrl_mch_s_axi_if #(.ADDR_W(8), .DATA_W(32)) s_axi ();

    matbi_dma_ctrl_mch_s_axi #(
        .NUM_CH(NUM_CH), .C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(s_axi), .interrupt(interrupt),
        .ch_ap_start(ch_ap_start), .ch_ap_done(ch_ap_done), .ch_ap_ready(ch_ap_ready),
        .ch_ap_idle(ch_ap_idle), .ch_rdma_ptr(ch_rdma_ptr), .ch_wdma_ptr(ch_wdma_ptr),
        .ch_xfer_byte(ch_xfer_byte), .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] rdma_at_b;
    logic [1:0]   resp;
    int           lat;
    int           n_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic drive_aw(input logic [7:0] addr);
        bit hs = 1'b0;
        s_axi.awaddr  = addr;
        s_axi.awvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge ACLK);
            hs = s_axi.awready;
            @(posedge ACLK); #1;
        end
        s_axi.awvalid = 1'b0;
        if (!hs) fail_timeout("aw_hs");
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
        bit hs = 1'b0;
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        s_axi.wvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge ACLK);
            hs = s_axi.wready;
            @(posedge ACLK); #1;
        end
        s_axi.wvalid = 1'b0;
        if (!hs) fail_timeout("w_hs");
    endtask

    task automatic wait_b(output logic [1:0] r, output int l);
        bit seen = 1'b0;
        r = 2'bxx;
        l = -1;
        s_axi.bready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (s_axi.bvalid) begin
                seen      = 1'b1;
                r         = s_axi.bresp;
                l         = i;
                rdma_at_b = ch_rdma_ptr;
            end
            @(posedge ACLK); #1;
        end
        s_axi.bready = 1'b0;
        if (!seen) fail_timeout("b_resp");
    endtask

    task automatic wr_check(input string tag, input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        int         l;
        fork
            drive_aw(addr);
            drive_w(data, strb);
        join
        wait_b(r, l);
        check({tag, "_bresp"}, r, exp_resp);
        check({tag, "_blat"}, l, 0);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        logic [31:0] d = 'x;
        logic [1:0]  r = 'x;
        int          l = -1;
        bit          hs = 1'b0;
        bit          seen = 1'b0;
        exp_q.push_back(exp_data);
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge ACLK);
            hs = s_axi.arready;
            @(posedge ACLK); #1;
        end
        s_axi.arvalid = 1'b0;
        if (!hs) fail_timeout({tag, "_ar"});
        s_axi.rready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (s_axi.rvalid) begin
                seen = 1'b1;
                d    = s_axi.rdata;
                r    = s_axi.rresp;
                l    = i;
            end
            @(posedge ACLK); #1;
        end
        s_axi.rready = 1'b0;
        if (!seen) fail_timeout({tag, "_r"});
        check({tag, "_rdata"}, d, exp_q.pop_front());
        check({tag, "_rresp"}, r, exp_resp);
        check({tag, "_rlat"}, l, 0);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] done_m, input logic [NUM_CH-1:0] ready_m);
        ch_ap_done  = done_m;
        ch_ap_ready = ready_m;
        @(posedge ACLK); #1;
        ch_ap_done  = '0;
        ch_ap_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN       = 1'b0;
        s_axi.awaddr  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.araddr  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;
        ch_ap_done    = '0;
        ch_ap_ready   = '0;
        ch_ap_idle    = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_ctl", {interrupt, ch_ap_start, s_axi.bvalid, s_axi.rvalid,
                          s_axi.awready, s_axi.wready, s_axi.arready}, '0);
        check("rst_ptr", {|ch_rdma_ptr, |ch_wdma_ptr, |ch_xfer_byte}, 3'b000);

        // READYs come up in the second cycle after release
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("rdy_cyc1", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        @(negedge ACLK);
        check("rdy_cyc2", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
        @(posedge ACLK); #1;

        rd_check("id", 8'h00, 32'h4D43_0004, 2'b00);
        rd_check("ctrl0_rst", 8'h10, 32'h0000_0000, 2'b00);

        wr_check("bm_full", 8'h24, 32'h1111_1111, 4'hF, 2'b00);
        wr_check("bm_part", 8'h24, 32'hDEAD_BEEF, 4'b0011, 2'b00);
        check("bm_ptr_at_b", rdma_at_b[63:32], 32'h1111_BEEF);
        check("bm_ptr", ch_rdma_ptr[63:32], 32'h1111_BEEF);
        rd_check("bm_rd", 8'h24, 32'h1111_BEEF, 2'b00);
        wr_check("xfer_hi", 8'h1C, 32'h1234_5678, 4'b1100, 2'b00);
        check("xfer_ptr", ch_xfer_byte[31:0], 32'h1234_0000);

        fork
            drive_w(32'hA5A5_0001, 4'hF);
            begin
                repeat (3) @(posedge ACLK);
                #1;
                drive_aw(8'h38);
            end
        join
        wait_b(resp, lat);
        check("wfirst_bresp", resp, 2'b00);
        check("wfirst_blat", lat, 0);
        n_b = 0;
        repeat (4) begin
            @(negedge ACLK);
            if (s_axi.bvalid) n_b++;
        end
        check("wfirst_single_b", n_b, 0);
        check("wfirst_ptr", ch_wdma_ptr[95:64], 32'hA5A5_0001);
        @(posedge ACLK); #1;

        wr_check("gie", 8'h04, 32'h1, 4'hF, 2'b00);
        wr_check("ier", 8'h08, 32'h4, 4'hF, 2'b00);
        wr_check("start2", 8'h30, 32'h1, 4'hF, 2'b00);
        check("start2_out", ch_ap_start, 4'b0100);
        pulse(4'b0000, 4'b0100);
        @(negedge ACLK);
        check("start2_ready", ch_ap_start, 4'b0000);
        @(posedge ACLK); #1;
        rd_check("ctrl2_ready", 8'h30, 32'h0000_0008, 2'b00);
        pulse(4'b0100, 4'b0000);
        @(negedge ACLK);
        check("irq_not_yet", interrupt, 1'b0);
        @(negedge ACLK);
        check("irq_set", interrupt, 1'b1);
        @(posedge ACLK); #1;
        rd_check("isr_set", 8'h0C, 32'h4, 2'b00);
        rd_check("ctrl2_done", 8'h30, 32'h0000_0002, 2'b00);
        rd_check("ctrl2_cor", 8'h30, 32'h0000_0000, 2'b00);
        wr_check("isr_clr", 8'h0C, 32'h4, 4'hF, 2'b00);
        @(negedge ACLK);
        check("irq_clr", interrupt, 1'b0);
        @(posedge ACLK); #1;
        rd_check("isr_zero", 8'h0C, 32'h0, 2'b00);

        // start write and ch_ap_ready in the same cycle: start stays set
        fork
            wr_check("start2_race", 8'h30, 32'h1, 4'hF, 2'b00);
            pulse(4'b0000, 4'b0100);
        join
        check("start2_race_out", ch_ap_start, 4'b0100);
        rd_check("ctrl2_race", 8'h30, 32'h0000_0009, 2'b00);

        wr_check("auto0", 8'h10, 32'h81, 4'hF, 2'b00);
        check("auto0_start", ch_ap_start, 4'b0101);
        pulse(4'b0000, 4'b0001);
        @(negedge ACLK);
        check("auto0_kept", ch_ap_start, 4'b0101);
        @(posedge ACLK); #1;
        rd_check("ctrl0_auto", 8'h10, 32'h0000_0081, 2'b00);

        rd_check("unmap_ch5", 8'h60, 32'h0, 2'b10);
        rd_check("unmap_perf", 8'hC0, 32'h0, 2'b10);
        wr_check("unmap_wr", 8'h60, 32'hFFFF_FFFF, 4'hF, 2'b10);
        check("unmap_wr_noeff", {|ch_rdma_ptr[127:64], ch_ap_start}, 5'b0_0101);

        wr_check("ier0", 8'h08, 32'h1, 4'hF, 2'b00);
        fork
            wr_check("isr_race", 8'h0C, 32'h1, 4'hF, 2'b00);
            pulse(4'b0001, 4'b0000);
        join
        rd_check("isr_race_rd", 8'h0C, 32'h1, 2'b00);
        @(negedge ACLK);
        check("isr_race_irq", interrupt, 1'b1);
        @(posedge ACLK); #1;
        rd_check("ctrl0_done", 8'h10, 32'h0000_0083, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
